// File: rtl/ic_pkg.sv
// ic_pkg: shared edge-select encodings and default widths for the input-capture path
package ic_pkg;
  localparam int FILT_W_DEF = 4;
  localparam int PSC_W_DEF  = 3;
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;
endpackage

// File: rtl/ic_glitch_filter.sv
// ic_glitch_filter: two-flop synchroniser plus stability counter with registered rise/fall strobes
module ic_glitch_filter
  import ic_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pin,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_pin_flt,
  output logic              o_rise,
  output logic              o_fall
);
  logic              r_s1, r_s2, r_flt, r_rise, r_fall;
  logic [FILT_W-1:0] r_fcnt;
  logic              w_diff, w_acc;
  assign w_diff    = r_s2 != r_flt;
  // >= rather than == so a length lowered mid-count is honoured at once instead of wrapping
  assign w_acc     = w_diff && (r_fcnt >= i_filt_len);
  assign o_pin_flt = r_flt;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  // synchronise, count stable cycles of a differing level, accept and strobe the edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_flt  <= 1'b0;
      r_fcnt <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_fcnt <= (!w_diff || w_acc) ? '0 : r_fcnt + 1'b1;
      r_flt  <= w_acc ? r_s2 : r_flt;
      r_rise <= w_acc & r_s2;
      r_fall <= w_acc & ~r_s2;
    end
  end
endmodule

// File: rtl/ic_input_cond.sv
// ic_input_cond: filtered edge detection, edge selection and prescaled single-cycle capture events
module ic_input_cond
  import ic_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF,
  parameter int PSC_W  = PSC_W_DEF
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_en,
  input  logic              i_pin,
  input  logic [1:0]        i_edge_sel,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic [PSC_W-1:0]  i_psc,
  input  logic              i_psc_clr,
  output logic              o_pin_flt,
  output logic              o_cap_evt
);
  logic             w_rise, w_fall, w_qual, w_fire;
  logic [PSC_W-1:0] r_psc_cnt;
  logic             r_evt;
  ic_glitch_filter #(.FILT_W(FILT_W)) u_flt (
    .i_clk      (i_sysclk),
    .i_rst      (i_sysrst),
    .i_pin      (i_pin),
    .i_filt_len (i_filt_len),
    .o_pin_flt  (o_pin_flt),
    .o_rise     (w_rise),
    .o_fall     (w_fall)
  );
  assign w_qual = (w_rise && (i_edge_sel == EDGE_RISE || i_edge_sel == EDGE_BOTH)) ||
                  (w_fall && (i_edge_sel == EDGE_FALL || i_edge_sel == EDGE_BOTH));
  // >= keeps an on-the-fly prescaler reduction from wrapping the counter
  assign w_fire = w_qual && (r_psc_cnt >= i_psc);
  assign o_cap_evt = r_evt;
  // prescaler count and event register; clear and disable both zero the count and suppress events
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      r_psc_cnt <= '0;
      r_evt     <= 1'b0;
    end else begin
      r_evt     <= !i_psc_clr && i_en && w_fire;
      r_psc_cnt <= (i_psc_clr || !i_en || w_fire) ? '0 : w_qual ? r_psc_cnt + 1'b1 : r_psc_cnt;
    end
  end
endmodule

// File: tb/tb_ic_input_cond.sv
// tb_ic_input_cond: directed stimulus with an event-time scoreboard for ic_input_cond
module tb_ic_input_cond;
  import ic_pkg::*;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b1, pin = 1'b1, psc_clr = 1'b0;
  logic [1:0] sel = EDGE_RISE;
  logic [3:0] filt = 4'd0;
  logic [2:0] psc = 3'd0;
  logic       pin_flt, cap_evt;
  int         cyc = 0;
  int         checks = 0, errors = 0;
  int         exp_q[$];
  int         mon_e;
  logic [1:0] sels[4] = '{EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE};

  ic_input_cond dut (
    .i_sysclk   (clk),
    .i_sysrst   (rst),
    .i_en       (en),
    .i_pin      (pin),
    .i_edge_sel (sel),
    .i_filt_len (filt),
    .i_psc      (psc),
    .i_psc_clr  (psc_clr),
    .o_pin_flt  (pin_flt),
    .o_cap_evt  (cap_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_evt === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_evt at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          errors++;
          $display("FAIL evt_time got cycle %0d want cycle %0d", cyc, mon_e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input logic v, input bit exp);
    pin = v;
    if (exp) exp_q.push_back(cyc + 4 + int'(filt));
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, req);
    end
  endtask

  task automatic pulse(input bit exp);
    set_pin(1'b1, exp);
    tick(3);
    set_pin(1'b0, 1'b0);
    tick(3);
  endtask

  initial begin
    tick(3);
    chk("reset_flt", pin_flt, 1'b0);
    chk("reset_evt", cap_evt, 1'b0);
    rst = 1'b0;
    set_pin(1'b1, 1'b1);
    tick(2);
    chk("rel_flt_early", pin_flt, 1'b0);
    tick(1);
    chk("rel_flt_high", pin_flt, 1'b1);
    tick(8);

    filt = 4'd3;
    set_pin(1'b0, 1'b0);
    tick(10);
    chk("flt_low", pin_flt, 1'b0);
    set_pin(1'b1, 1'b0);
    tick(3);
    set_pin(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("glitch_flt", pin_flt, 1'b0);
    end
    tick(4);
    set_pin(1'b1, 1'b1);
    tick(4);
    chk("filt_k3", pin_flt, 1'b0);
    tick(1);
    chk("filt_k4", pin_flt, 1'b0);
    tick(1);
    chk("filt_k5", pin_flt, 1'b1);
    set_pin(1'b0, 1'b0);
    tick(12);

    filt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      for (int p = 0; p < 2; p++) begin
        set_pin(1'b1, sels[i][0]);
        tick(5);
        set_pin(1'b0, sels[i][1]);
        tick(5);
      end
    end
    tick(5);

    sel = EDGE_RISE;
    psc = 3'd2;
    psc_clr = 1'b1;
    tick(1);
    psc_clr = 1'b0;
    for (int e = 1; e <= 9; e++) pulse(e % 3 == 0);
    psc = 3'd5;
    for (int e = 0; e < 3; e++) pulse(1'b0);
    psc = 3'd1;
    pulse(1'b1);

    psc = 3'd2;
    pulse(1'b0);
    pulse(1'b0);
    set_pin(1'b1, 1'b0);
    tick(3);
    psc_clr = 1'b1;
    tick(1);
    psc_clr = 1'b0;
    tick(2);
    set_pin(1'b0, 1'b0);
    tick(3);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    en = 1'b0;
    for (int e = 0; e < 4; e++) pulse(1'b0);
    en = 1'b1;
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b1);

    psc = 3'd0;
    filt = 4'd3;
    set_pin(1'b1, 1'b1);
    tick(12);
    chk("pre_rst_flt", pin_flt, 1'b1);
    set_pin(1'b0, 1'b0);
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flt", pin_flt, 1'b0);
    chk("async_rst_evt", cap_evt, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(12);
    chk("post_rst_flt", pin_flt, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_evts got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
